// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_ctrl_pkg
//  Description : Shared definitions for the LCD_CTRL command sequencer:
//                opcode constants, sequencer state encoding, error codes and
//                a small state-classification helper.
//  Revision    : 1.0  initial release
// ============================================================================
package lcd_ctrl_pkg;

  // LCD_CTRL opcodes
  localparam logic [3:0] OP_WRITE       = 4'h0;
  localparam logic [3:0] OP_SHIFT_UP    = 4'h1;
  localparam logic [3:0] OP_SHIFT_DOWN  = 4'h2;
  localparam logic [3:0] OP_SHIFT_LEFT  = 4'h3;
  localparam logic [3:0] OP_SHIFT_RIGHT = 4'h4;
  localparam logic [3:0] OP_MAX         = 4'h5;
  localparam logic [3:0] OP_MIN         = 4'h6;
  localparam logic [3:0] OP_AVG         = 4'h7;
  localparam logic [3:0] OP_CCW         = 4'h8;
  localparam logic [3:0] OP_CW          = 4'h9;
  localparam logic [3:0] OP_MIRROR_X    = 4'hA;
  localparam logic [3:0] OP_MIRROR_Y    = 4'hB;

  // Job completion codes reported on err
  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_NO_WRITE = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LOAD      = 3'd2,
    S_ISSUE     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_RDY  = 3'd5,
    S_WAIT_DONE = 3'd6,
    S_FINISH    = 3'd7
  } seq_state_t;

  // States in which the sequencer is waiting on LCD_CTRL and can time out
  function automatic logic is_timed_state(input seq_state_t s);
    return (s == S_ISSUE) || (s == S_WAIT_RDY) || (s == S_WAIT_DONE);
  endfunction

endpackage : lcd_ctrl_pkg
`default_nettype wire

// File: rtl/lcd_seq_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_seq_timeout
//  Description : Loadable down-counter used as the sequencer wait watchdog.
//                load presets the count to TIMEOUT-1 so that expired rises on
//                the TIMEOUT-th cycle spent counting after the load.
//  Ports       : clk      - clock, rising edge
//                reset    - asynchronous, active-low
//                clr      - force count to zero (parks the counter)
//                load     - preset count to TIMEOUT-1 (clr has priority)
//                en       - decrement while nonzero
//                expired  - count is zero
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_seq_timeout #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int         CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = LOAD_VAL;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule : lcd_seq_timeout
`default_nettype wire

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_cmd_sequencer
//  Description : Issues LCD_CTRL opcodes fetched from a registered command ROM
//                over the cmd/cmd_valid/busy handshake, then waits for done
//                after the WRITE opcode and reports the job outcome.
//  Ports       : clk, reset        - clock / async active-low reset
//                start, n_cmd      - job start pulse and ROM entry count
//                cmd_rd, cmd_a     - ROM read strobe and address
//                cmd_q             - ROM data (one cycle after cmd_rd)
//                cmd, cmd_valid    - opcode and single-cycle valid to LCD_CTRL
//                busy, done        - LCD_CTRL status
//                running, finished - job in progress / job ended (level)
//                err               - 0 ok, 1 no WRITE opcode, 2 timeout
//                issued_cnt        - opcodes issued in the current job
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_cmd_sequencer
  import lcd_ctrl_pkg::*;
#(
  parameter int               AW       = 6,
  parameter int               CMD_W    = 4,
  parameter logic [CMD_W-1:0] WRITE_OP = CMD_W'(OP_WRITE),
  parameter int               TIMEOUT  = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW:0]      n_cmd,
  output logic             cmd_rd,
  output logic [AW-1:0]    cmd_a,
  input  logic [CMD_W-1:0] cmd_q,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic             running,
  output logic             finished,
  output logic [1:0]       err,
  output logic [AW:0]      issued_cnt
);

  localparam logic [AW:0] ISSUED_MAX = {1'b1, {AW{1'b0}}};

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    cmd_a_q, cmd_a_d;
  logic [CMD_W-1:0] opcode_q, opcode_d;
  logic [AW:0]      n_cmd_q, n_cmd_d;
  logic [AW:0]      issued_cnt_q, issued_cnt_d;
  logic             running_q, running_d;
  logic             finished_q, finished_d;
  logic [1:0]       err_q, err_d;

  logic             issue_fire;
  logic             go_finish;
  logic [1:0]       fin_code;

  logic             timer_en;
  logic             timer_load;
  logic             timer_clr;
  logic             timer_expired;
  logic             timed_out;
  logic             state_change;

  // --------------------------------------------------------------------------
  // Wait watchdog: rearmed on entry to any waiting state, parked otherwise.
  // --------------------------------------------------------------------------
  assign timer_en     = is_timed_state(state_q);
  assign timed_out    = timer_en && timer_expired;
  assign state_change = (state_d != state_q);
  assign timer_load   = state_change && is_timed_state(state_d);
  assign timer_clr    = state_change && !is_timed_state(state_d);

  lcd_seq_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (timer_clr),
    .load    (timer_load),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cmd_a_d      = cmd_a_q;
    opcode_d     = opcode_q;
    n_cmd_d      = n_cmd_q;
    issued_cnt_d = issued_cnt_q;
    running_d    = running_q;
    finished_d   = finished_q;
    err_d        = err_q;
    issue_fire   = 1'b0;
    go_finish    = 1'b0;
    fin_code     = ERR_OK;

    unique case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          n_cmd_d      = n_cmd;
          issued_cnt_d = '0;
          err_d        = ERR_OK;
          finished_d   = 1'b0;
          running_d    = 1'b1;
          cmd_a_d      = '0;
          if (n_cmd == '0) begin
            go_finish = 1'b1;
            fin_code  = ERR_NO_WRITE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        opcode_d = cmd_q;
        state_d  = S_ISSUE;
      end

      S_ISSUE: begin
        // Timeout wins so no pulse can escape on the abort cycle
        if (timed_out) begin
          go_finish = 1'b1;
          fin_code  = ERR_TIMEOUT;
        end else if (!busy) begin
          issue_fire = 1'b1;
          if (issued_cnt_q != ISSUED_MAX) begin
            issued_cnt_d = issued_cnt_q + (AW+1)'(1);
          end
          state_d = S_ACK;
        end
      end

      // LCD_CTRL raises busy one cycle after accepting, so busy is not
      // trustworthy until this dead cycle has passed.
      S_ACK: state_d = (opcode_q == WRITE_OP) ? S_WAIT_DONE : S_WAIT_RDY;

      S_WAIT_RDY: begin
        if (timed_out) begin
          go_finish = 1'b1;
          fin_code  = ERR_TIMEOUT;
        end else if (!busy) begin
          if (issued_cnt_q == n_cmd_q) begin
            go_finish = 1'b1;
            fin_code  = ERR_NO_WRITE;
          end else begin
            cmd_a_d = cmd_a_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end

      S_WAIT_DONE: begin
        // busy is deliberately not looked at here: done alone ends the job
        if (timed_out) begin
          go_finish = 1'b1;
          fin_code  = ERR_TIMEOUT;
        end else if (done) begin
          go_finish = 1'b1;
          fin_code  = ERR_OK;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (go_finish) begin
      state_d    = S_FINISH;
      running_d  = 1'b0;
      finished_d = 1'b1;
      err_d      = fin_code;
    end
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cmd_a_q      <= '0;
      opcode_q     <= '0;
      n_cmd_q      <= '0;
      issued_cnt_q <= '0;
      running_q    <= 1'b0;
      finished_q   <= 1'b0;
      err_q        <= ERR_OK;
    end else begin
      state_q      <= state_d;
      cmd_a_q      <= cmd_a_d;
      opcode_q     <= opcode_d;
      n_cmd_q      <= n_cmd_d;
      issued_cnt_q <= issued_cnt_d;
      running_q    <= running_d;
      finished_q   <= finished_d;
      err_q        <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. cmd is zeroed outside the valid pulse so LCD_CTRL never sees a
  // stale opcode on an idle bus.
  // --------------------------------------------------------------------------
  assign cmd_rd     = (state_q == S_FETCH);
  assign cmd_a      = cmd_a_q;
  assign cmd_valid  = issue_fire;
  assign cmd        = issue_fire ? opcode_q : '0;
  assign running    = running_q;
  assign finished   = finished_q;
  assign err        = err_q;
  assign issued_cnt = issued_cnt_q;

endmodule : lcd_cmd_sequencer
`default_nettype wire

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
Synthesizable command issuer for LCD_CTRL. It is the transmitting end of the cmd/cmd_valid/busy handshake that LCD_CTRL receives on. It fetches 4-bit opcodes from a synchronous command ROM and issues each one only when LCD_CTRL is not busy. After issuing the WRITE opcode it waits for done and reports completion, so a stand-alone top can run an LCD_CTRL job without the bench driver.

Parameters:
AW, 6, command ROM address width
CMD_W, 4, opcode width
WRITE_OP, 4'h0, opcode that ends the job (LCD_CTRL writes back, then pulses done)
TIMEOUT, 1023, maximum cycles spent waiting on busy high or on done before the job aborts

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low
start  in  1  one-cycle pulse that begins a job; ignored unless in IDLE or FINISH
n_cmd  in  AW+1  number of ROM entries available; sampled on start; 0 is legal
cmd_rd  out  1  command ROM read strobe
cmd_a  out  AW  command ROM address
cmd_q  in  CMD_W  ROM data, valid the cycle after cmd_rd (registered ROM)
cmd  out  CMD_W  opcode to LCD_CTRL
cmd_valid  out  1  opcode valid, single-cycle pulse
busy  in  1  LCD_CTRL busy
done  in  1  LCD_CTRL job complete
running  out  1  job in progress
finished  out  1  level; job ended (clean or error); cleared on next start
err  out  2  0 ok, 1 no WRITE_OP within n_cmd, 2 timeout
issued_cnt  out  AW+1  commands issued in the current job

Behaviour:
- Reset values: cmd_rd=0, cmd_a=0, cmd=0, cmd_valid=0, running=0, finished=0, err=0, issued_cnt=0. FSM goes to IDLE. An active reset mid-job aborts immediately; no partial pulse is emitted.
- States: IDLE, FETCH, LOAD, ISSUE, ACK, WAIT_RDY, WAIT_DONE, FINISH.
- IDLE/FINISH + start:
  - Latch n_cmd; clear issued_cnt, err and finished; running=1.
  - If n_cmd==0, go to FINISH with err=1.
  - Otherwise cmd_a=0, go to FETCH.
- FETCH: cmd_rd=1 for one cycle, go to LOAD.
- LOAD: capture cmd_q into the opcode register, go to ISSUE.
- ISSUE:
  - If busy==0 this cycle: cmd_valid=1 and cmd=opcode for exactly one cycle, issued_cnt+1, go to ACK.
  - If busy==1: hold with cmd_valid=0.
- ACK: one dead cycle that covers LCD_CTRL's registered busy rise. cmd_valid=0.
  - If opcode==WRITE_OP, go to WAIT_DONE.
  - Else go to WAIT_RDY.
- WAIT_RDY:
  - On busy==0: if issued_cnt==latched n_cmd, go to FINISH with err=1. Otherwise cmd_a+1 and go to FETCH.
  - Prefetch is allowed: FETCH/LOAD may overlap WAIT_RDY, provided cmd_valid is never asserted while busy==1.
- WAIT_DONE: on done==1 go to FINISH with err=0. If done and busy are both high, done wins.
- FINISH: running=0, finished=1, outputs hold until the next start.
- Timeout:
  - One counter, cleared on every state entry, counts in ISSUE, WAIT_RDY and WAIT_DONE.
  - When the count reaches TIMEOUT: go to FINISH with err=2, cmd_valid forced 0.
- start is ignored in every state other than IDLE/FINISH.
- A done seen outside WAIT_DONE is ignored.
- issued_cnt saturates at 2^AW. cmd_a never wraps within a job because n_cmd ≤ 2^AW.
- Issue latency: when busy is low, the first cmd_valid comes 3 cycles after start (FETCH, LOAD, ISSUE).

Decomposition:
- Package lcd_ctrl_pkg:
  - Opcode constants: WRITE=0, SHIFT_UP=1, SHIFT_DOWN=2, SHIFT_LEFT=3, SHIFT_RIGHT=4, MAX=5, MIN=6, AVG=7, CCW=8, CW=9, MIRROR_X=A, MIRROR_Y=B.
  - seq_state_t enum.
  - err code constants.
- Sub-module: lcd_seq_timeout, a loadable down-counter with a clear and an expired flag.

Test Plan:
- Three-opcode job:
  - Stimulus: ROM={1,7,0}, n_cmd=3, model busy high for 4 cycles after each accepted command, done 2 cycles after the WRITE is accepted.
  - Required: cmd_valid pulses carry 1, 7, 0 in order, none while busy; finished=1, err=0, issued_cnt=3.
- Back-pressure:
  - Stimulus: hold busy=1 for 20 cycles before the first issue.
  - Required: cmd_valid stays 0 throughout; the first pulse comes the cycle busy falls; no duplicate pulse.
- Missing WRITE:
  - Stimulus: ROM={3,4}, n_cmd=2.
  - Required: 2 issues, then finished=1, err=1.
- n_cmd=0:
  - Stimulus: start with n_cmd=0.
  - Required: finished the next cycle, err=1, no cmd_rd and no cmd_valid.
- Timeout:
  - Stimulus: TIMEOUT=15, busy stuck at 1.
  - Required: finished with err=2 exactly 15 cycles after entering ISSUE.
- Reset and restart:
  - Stimulus: assert reset low mid WAIT_RDY, release, then start a 46-entry job replayed from a cmd3.dat image.
  - Required: all outputs read 0 during reset; the full job completes and the IRAM content matches tb3_goal.
